// File: rtl/arb_sink_fifo.sv
// Tagged FWFT FIFO behind the 4-source round arbiter: stores every granted word with its
// binary source index, or drops it and accounts for it (sticky flags plus a saturating counter).
module arb_sink_fifo #(
  parameter int unsigned BIT_DEPTH = 8,
  parameter int unsigned T_AMOUNT  = 4,
  parameter int unsigned DEPTH     = 8,
  parameter int unsigned CNT_W     = 8
) (
  input  logic                        clk,
  input  logic                        arst,
  input  logic [BIT_DEPTH-1:0]        s_data_i,
  input  logic                        s_valid_i,
  input  logic [T_AMOUNT-1:0]         s_number_i,
  output logic [BIT_DEPTH-1:0]        m_data_o,
  output logic [$clog2(T_AMOUNT)-1:0] m_src_o,
  output logic                        m_valid_o,
  input  logic                        m_ready_i,
  output logic [$clog2(DEPTH):0]      level_o,
  output logic                        full_o,
  output logic                        overflow_o,
  output logic                        tag_err_o,
  output logic [CNT_W-1:0]            drop_cnt_o,
  input  logic                        clr_i
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned LVL_W = PTR_W + 1;
  localparam int unsigned SRC_W = $clog2(T_AMOUNT);

  logic [BIT_DEPTH-1:0] mem_data [DEPTH];
  logic [SRC_W-1:0]     mem_src  [DEPTH];

  logic [PTR_W-1:0]     rd_ptr, wr_ptr, rd_nxt;
  logic [LVL_W-1:0]     level_nxt;
  logic [BIT_DEPTH-1:0] head_data_nxt;
  logic [SRC_W-1:0]     head_src_nxt;
  logic                 tag_ok;
  logic [SRC_W-1:0]     tag_idx;
  logic                 pop, push, drop, bad_tag, full_drop;

  // One-hot check and tag-to-index conversion
  always_comb begin
    tag_ok  = (s_number_i != '0) &&
              ((s_number_i & (s_number_i - T_AMOUNT'(1))) == '0);
    tag_idx = '0;
    for (int i = 0; i < int'(T_AMOUNT); i++) begin
      if (s_number_i[i]) tag_idx = SRC_W'(i);
    end
  end

  assign pop       = m_valid_o & m_ready_i;
  assign push      = s_valid_i & tag_ok & ((level_o < LVL_W'(DEPTH)) | pop);
  assign drop      = s_valid_i & ~push;
  assign bad_tag   = s_valid_i & ~tag_ok;
  assign full_drop = s_valid_i & tag_ok & ~push;

  // Next pointer/level and the word that will sit at the head after this edge
  always_comb begin
    rd_nxt        = pop ? rd_ptr + PTR_W'(1) : rd_ptr;
    level_nxt     = level_o;
    head_data_nxt = '0;
    head_src_nxt  = '0;
    if (push && !pop)      level_nxt = level_o + LVL_W'(1);
    else if (pop && !push) level_nxt = level_o - LVL_W'(1);
    if (level_nxt != '0) begin
      // An empty-before-edge push lands at rd_nxt and must bypass the memory read
      if (push && (rd_nxt == wr_ptr)) begin
        head_data_nxt = s_data_i;
        head_src_nxt  = tag_idx;
      end else begin
        head_data_nxt = mem_data[rd_nxt];
        head_src_nxt  = mem_src[rd_nxt];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      mem_data[wr_ptr] <= s_data_i;
      mem_src[wr_ptr]  <= tag_idx;
    end
  end

  // Pointers, occupancy and registered head
  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      rd_ptr    <= '0;
      wr_ptr    <= '0;
      level_o   <= '0;
      full_o    <= 1'b0;
      m_valid_o <= 1'b0;
      m_data_o  <= '0;
      m_src_o   <= '0;
    end else begin
      rd_ptr    <= rd_nxt;
      wr_ptr    <= push ? wr_ptr + PTR_W'(1) : wr_ptr;
      level_o   <= level_nxt;
      full_o    <= (level_nxt == LVL_W'(DEPTH));
      m_valid_o <= (level_nxt != '0);
      m_data_o  <= head_data_nxt;
      m_src_o   <= head_src_nxt;
    end
  end

  // Drop accounting; clear wins over a same-cycle drop
  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      overflow_o <= 1'b0;
      tag_err_o  <= 1'b0;
      drop_cnt_o <= '0;
    end else if (clr_i) begin
      overflow_o <= 1'b0;
      tag_err_o  <= 1'b0;
      drop_cnt_o <= '0;
    end else begin
      overflow_o <= overflow_o | full_drop;
      tag_err_o  <= tag_err_o | bad_tag;
      if (drop && (drop_cnt_o != '1)) drop_cnt_o <= drop_cnt_o + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_arb_sink_fifo.sv
// Self-checking bench for arb_sink_fifo: directed table, corner sequences and random
// traffic compared against a queue-based reference model.
module tb_arb_sink_fifo;

  logic       clk = 1'b0;
  logic       arst;
  logic [7:0] s_data_i;
  logic       s_valid_i;
  logic [3:0] s_number_i;
  logic [7:0] m_data_o;
  logic [1:0] m_src_o;
  logic       m_valid_o;
  logic       m_ready_i;
  logic [3:0] level_o;
  logic       full_o;
  logic       overflow_o;
  logic       tag_err_o;
  logic [7:0] drop_cnt_o;
  logic       clr_i;

  arb_sink_fifo dut (
    .clk(clk), .arst(arst),
    .s_data_i(s_data_i), .s_valid_i(s_valid_i), .s_number_i(s_number_i),
    .m_data_o(m_data_o), .m_src_o(m_src_o), .m_valid_o(m_valid_o), .m_ready_i(m_ready_i),
    .level_o(level_o), .full_o(full_o), .overflow_o(overflow_o), .tag_err_o(tag_err_o),
    .drop_cnt_o(drop_cnt_o), .clr_i(clr_i)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  typedef struct { logic [7:0] d; logic [1:0] s; } ent_t;
  ent_t q[$];
  bit   m_ovf, m_terr;
  int   m_cnt;

  typedef struct {
    logic v; logic [7:0] d; logic [3:0] t; logic r; logic c;
    logic ev; logic [7:0] ed; logic [1:0] es; logic [3:0] el;
  } vec_t;
  vec_t tbl[5];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  function automatic int tag_pos(input logic [3:0] t);
    int p = 0;
    for (int i = 0; i < 4; i++) if (t[i]) p = i;
    return p;
  endfunction

  // Reference model: one clock edge worth of spec rules on the queue
  task automatic model_edge(input logic v, input logic [7:0] d, input logic [3:0] t,
                            input logic r, input logic c);
    bit onehot = ($countones(t) == 1);
    bit pop    = (q.size() > 0) && r;
    bit push   = v && onehot && ((q.size() < 8) || pop);
    bit drop   = v && !push;
    ent_t e;
    if (pop) void'(q.pop_front());
    if (push) begin
      e.d = d; e.s = 2'(tag_pos(t));
      q.push_back(e);
    end
    if (c) begin
      m_ovf = 0; m_terr = 0; m_cnt = 0;
    end else begin
      if (v && !onehot) m_terr = 1;
      if (v && onehot && !push) m_ovf = 1;
      if (drop && m_cnt < 255) m_cnt++;
    end
  endtask

  task automatic model_cmp(input string nm);
    chk({nm, ".valid"}, 32'(m_valid_o), 32'(q.size() != 0));
    chk({nm, ".data"},  32'(m_data_o),  q.size() ? 32'(q[0].d) : 32'd0);
    chk({nm, ".src"},   32'(m_src_o),   q.size() ? 32'(q[0].s) : 32'd0);
    chk({nm, ".level"}, 32'(level_o),   32'(q.size()));
    chk({nm, ".full"},  32'(full_o),    32'(q.size() == 8));
    chk({nm, ".ovf"},   32'(overflow_o), 32'(m_ovf));
    chk({nm, ".terr"},  32'(tag_err_o), 32'(m_terr));
    chk({nm, ".cnt"},   32'(drop_cnt_o), 32'(m_cnt));
  endtask

  // Drive one cycle, clock it, then check against the model 1 time unit later
  task automatic step(input string nm, input logic v, input logic [7:0] d, input logic [3:0] t,
                      input logic r, input logic c);
    s_valid_i = v; s_data_i = d; s_number_i = t; m_ready_i = r; clr_i = c;
    @(posedge clk);
    model_edge(v, d, t, r, c);
    #1;
    model_cmp(nm);
  endtask

  task automatic idle(input string nm, input logic r);
    step(nm, 1'b0, 8'h00, 4'b0000, r, 1'b0);
  endtask

  initial begin
    tbl[0] = '{1'b1, 8'h11, 4'b0001, 1'b1, 1'b0, 1'b1, 8'h11, 2'd0, 4'd1};
    tbl[1] = '{1'b1, 8'h22, 4'b0010, 1'b1, 1'b0, 1'b1, 8'h22, 2'd1, 4'd1};
    tbl[2] = '{1'b1, 8'h33, 4'b0100, 1'b1, 1'b0, 1'b1, 8'h33, 2'd2, 4'd1};
    tbl[3] = '{1'b1, 8'h44, 4'b1000, 1'b1, 1'b0, 1'b1, 8'h44, 2'd3, 4'd1};
    tbl[4] = '{1'b0, 8'h00, 4'b0000, 1'b1, 1'b0, 1'b0, 8'h00, 2'd0, 4'd0};

    arst = 1'b1; s_valid_i = 0; s_data_i = 0; s_number_i = 0; m_ready_i = 0; clr_i = 0;
    m_ovf = 0; m_terr = 0; m_cnt = 0;
    repeat (2) @(posedge clk);
    #1;
    model_cmp("reset");
    arst = 1'b0;

    // Burst through an always-ready consumer
    for (int i = 0; i < 5; i++) begin
      step("burst", tbl[i].v, tbl[i].d, tbl[i].t, tbl[i].r, tbl[i].c);
      chk("burst_tbl.valid", 32'(m_valid_o), 32'(tbl[i].ev));
      chk("burst_tbl.data",  32'(m_data_o),  32'(tbl[i].ed));
      chk("burst_tbl.src",   32'(m_src_o),   32'(tbl[i].es));
      chk("burst_tbl.level", 32'(level_o),   32'(tbl[i].el));
    end

    // Fill past capacity with no consumer
    for (int i = 0; i < 10; i++) begin
      step("fill", 1'b1, 8'(i), 4'(1 << (i % 4)), 1'b0, 1'b0);
      if (i == 7) chk("fill.full8", 32'(full_o), 32'd1);
    end
    chk("fill.ovf", 32'(overflow_o), 32'd1);
    chk("fill.cnt", 32'(drop_cnt_o), 32'd2);
    for (int i = 0; i < 8; i++) begin
      chk("drain.data", 32'(m_data_o), 32'(i));
      idle("drain", 1'b1);
    end
    chk("drain.empty", 32'(m_valid_o), 32'd0);
    step("clr", 1'b0, 8'h00, 4'b0000, 1'b0, 1'b1);
    chk("clr.ovf", 32'(overflow_o), 32'd0);

    // Full plus concurrent pop accepts the word
    for (int i = 0; i < 8; i++) step("refill", 1'b1, 8'(8'h10 + i), 4'b0100, 1'b0, 1'b0);
    step("fullpop", 1'b1, 8'hA5, 4'b0001, 1'b1, 1'b0);
    chk("fullpop.level", 32'(level_o), 32'd8);
    chk("fullpop.ovf", 32'(overflow_o), 32'd0);
    for (int i = 0; i < 8; i++) begin
      if (i == 7) chk("fullpop.last", 32'(m_data_o), 32'hA5);
      idle("fullpop_drain", 1'b1);
    end

    // Bad tags on an empty FIFO, then clear; then clear racing a drop
    step("badtag", 1'b1, 8'h55, 4'b0011, 1'b1, 1'b0);
    step("badtag", 1'b1, 8'h66, 4'b0000, 1'b1, 1'b0);
    chk("badtag.valid", 32'(m_valid_o), 32'd0);
    chk("badtag.terr", 32'(tag_err_o), 32'd1);
    chk("badtag.cnt", 32'(drop_cnt_o), 32'd2);
    step("badtag_clr", 1'b0, 8'h00, 4'b0000, 1'b0, 1'b1);
    chk("badtag_clr.cnt", 32'(drop_cnt_o), 32'd0);
    step("clr_race", 1'b1, 8'h77, 4'b1010, 1'b0, 1'b1);
    chk("clr_race.terr", 32'(tag_err_o), 32'd0);

    // Counter saturation
    for (int i = 0; i < 300; i++) step("sat", 1'b1, 8'h00, 4'b1111, 1'b0, 1'b0);
    chk("sat.cnt", 32'(drop_cnt_o), 32'd255);
    step("sat_clr", 1'b0, 8'h00, 4'b0000, 1'b0, 1'b1);

    // Stall stability then drain
    step("stall_ld", 1'b1, 8'hC1, 4'b1000, 1'b0, 1'b0);
    step("stall_ld", 1'b1, 8'hC2, 4'b0010, 1'b0, 1'b0);
    step("stall_ld", 1'b1, 8'hC3, 4'b0001, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) begin
      idle("stall", 1'b0);
      chk("stall.data", 32'(m_data_o), 32'hC1);
      chk("stall.src", 32'(m_src_o), 32'd3);
    end
    for (int i = 0; i < 3; i++) idle("stall_drain", 1'b1);
    chk("stall_drain.valid", 32'(m_valid_o), 32'd0);

    // Asynchronous reset mid-operation
    step("pre_rst", 1'b1, 8'h00, 4'b0110, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) step("pre_rst", 1'b1, 8'(8'h30 + i), 4'b0001, 1'b0, 1'b0);
    chk("pre_rst.level", 32'(level_o), 32'd5);
    #3 arst = 1'b1;
    #1;
    q.delete(); m_ovf = 0; m_terr = 0; m_cnt = 0;
    model_cmp("async_rst");
    #1 arst = 1'b0;
    step("post_rst", 1'b1, 8'h9E, 4'b0100, 1'b0, 1'b0);
    chk("post_rst.level", 32'(level_o), 32'd1);
    chk("post_rst.data", 32'(m_data_o), 32'h9E);

    // Random traffic against the model
    for (int n = 0; n < 3000; n++) begin
      logic       v = ($urandom_range(99) < 70);
      logic [3:0] t = ($urandom_range(9) == 0) ? 4'($urandom) : 4'(1 << $urandom_range(3));
      logic       r = ($urandom_range(99) < 45);
      logic       c = ($urandom_range(99) < 3);
      step("rand", v, 8'($urandom), t, r, c);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
